// File: rtl/bg_copy_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bg_copy_pkg
//  Purpose  : Shared types and default constants for the background copier.
//  Revision : 1.0 - initial release
// ============================================================================
package bg_copy_pkg;

  // Copy sequencer states.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_READ  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // One 640x480 byte image packed two bytes per word.
  localparam int DEFAULT_WORDS_PER_BG = 153600;
  // Image plus one terminator word between consecutive backgrounds.
  localparam int DEFAULT_BG_STRIDE    = 153601;
  // Words strictly above this value end the copy early.
  localparam logic [15:0] DEFAULT_SENTINEL = 16'hF000;

endpackage : bg_copy_pkg
`default_nettype wire

// File: rtl/bg_copy_engine_if.sv
`default_nettype none
// ============================================================================
//  Module   : bg_copy_engine_if
//  Purpose  : Control, SRAM-read and OCM-write signals of the copier.
//  Revision : 1.0 - initial release
// ============================================================================
interface bg_copy_engine_if #(
  parameter int DW      = 16,
  parameter int SRAM_AW = 20,
  parameter int OCM_AW  = 19,
  parameter int SELW    = 2
);
  logic                load;
  logic [SELW-1:0]     BG_Sel;
  logic                SRAM_done;
  logic [DW-1:0]       DATA_IN;
  logic                ocm_ready;
  logic                reading;
  logic                writing;
  logic [SRAM_AW-1:0]  ADDR;
  logic [OCM_AW-1:0]   addr_OCM;
  logic [DW-1:0]       DATA_OUT;
  logic                busy;
  logic                done;
  logic [OCM_AW-1:0]   words_written;

  // Copier side.
  modport master (
    input  load, BG_Sel, SRAM_done, DATA_IN, ocm_ready,
    output reading, writing, ADDR, addr_OCM, DATA_OUT, busy, done, words_written
  );

  // Controller / memory side.
  modport slave (
    output load, BG_Sel, SRAM_done, DATA_IN, ocm_ready,
    input  reading, writing, ADDR, addr_OCM, DATA_OUT, busy, done, words_written
  );
endinterface : bg_copy_engine_if
`default_nettype wire

// File: rtl/bg_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : bg_addr_gen
//  Purpose  : Background base computation plus SRAM/OCM address and
//             accepted-word counters for the copier.
//  Revision : 1.0 - initial release
// ============================================================================
module bg_addr_gen
  import bg_copy_pkg::*;
#(
  parameter int SRAM_AW      = 20,
  parameter int OCM_AW       = 19,
  parameter int SELW         = 2,
  parameter int NUM_BG       = 4,
  parameter int WORDS_PER_BG = DEFAULT_WORDS_PER_BG,
  parameter int BG_STRIDE    = DEFAULT_BG_STRIDE
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [SELW-1:0]     i_sel,
  input  logic                i_load_base,
  input  logic                i_incr,
  output logic [SRAM_AW-1:0]  o_addr,
  output logic [OCM_AW-1:0]   o_addr_ocm,
  output logic [OCM_AW-1:0]   o_words,
  output logic                o_last
);

  localparam logic [SRAM_AW-1:0] c_STRIDE = SRAM_AW'(BG_STRIDE);
  localparam logic [OCM_AW-1:0]  c_WORDS  = OCM_AW'(WORDS_PER_BG);

  localparam longint c_LAST_END = longint'(NUM_BG - 1) * longint'(BG_STRIDE)
                                + longint'(WORDS_PER_BG);

  // Address counters never wrap, so the parameter set must keep every copy in range.
  if (c_LAST_END > (longint'(1) << SRAM_AW)) begin : g_chk_sram_range
    $error("bg_addr_gen: last background runs past the SRAM address space");
  end
  if (longint'(WORDS_PER_BG) > (longint'(1) << OCM_AW)) begin : g_chk_ocm_range
    $error("bg_addr_gen: WORDS_PER_BG exceeds the OCM address space");
  end

  logic                w_sel_ok;
  logic [SRAM_AW-1:0]  w_base;
  logic [SRAM_AW-1:0]  r_addr;
  logic [OCM_AW-1:0]   r_addr_ocm;
  logic [OCM_AW-1:0]   r_words;
  logic [OCM_AW-1:0]   w_words_inc;

  // Out-of-range selects fall back to the first background.
  assign w_sel_ok    = (32'(i_sel) < 32'(NUM_BG));
  assign w_base      = w_sel_ok ? (SRAM_AW'(i_sel) * c_STRIDE) : '0;
  assign w_words_inc = r_words + 1'b1;

  // Base load at copy start; all three counters step together per accepted write.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_addr     <= '0;
      r_addr_ocm <= '0;
      r_words    <= '0;
    end else if (i_load_base) begin
      r_addr     <= w_base;
      r_addr_ocm <= '0;
      r_words    <= '0;
    end else if (i_incr) begin
      r_addr     <= r_addr + 1'b1;
      r_addr_ocm <= r_addr_ocm + 1'b1;
      r_words    <= w_words_inc;
    end
  end

  assign o_addr     = r_addr;
  assign o_addr_ocm = r_addr_ocm;
  assign o_words    = r_words;
  // The write being accepted now completes the image.
  assign o_last     = (w_words_inc == c_WORDS);

endmodule : bg_addr_gen
`default_nettype wire

// File: rtl/bg_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module   : bg_copy_engine
//  Purpose  : Copies one background image word by word from SRAM into the
//             OCM frame buffer, with count/sentinel termination and abort.
//  Revision : 1.0 - initial release
// ============================================================================
module bg_copy_engine
  import bg_copy_pkg::*;
#(
  parameter int              DW           = 16,
  parameter int              SRAM_AW      = 20,
  parameter int              OCM_AW       = 19,
  parameter int              NUM_BG       = 4,
  parameter int              SELW         = 2,
  parameter int              WORDS_PER_BG = DEFAULT_WORDS_PER_BG,
  parameter int              BG_STRIDE    = DEFAULT_BG_STRIDE,
  parameter int              SENTINEL_EN  = 1,
  parameter logic [DW-1:0]   SENTINEL     = DW'(DEFAULT_SENTINEL)
) (
  input  logic             Clk,
  input  logic             Reset,
  bg_copy_engine_if.master bus
);

  state_t         r_state;
  state_t         w_state_next;
  logic           w_load_base;
  logic           w_incr;
  logic           w_latch;
  logic           w_last;
  logic           w_sentinel_hit;
  logic [DW-1:0]  r_data_out;

  assign w_sentinel_hit = (SENTINEL_EN != 0) && (bus.DATA_IN > SENTINEL);

  bg_addr_gen #(
    .SRAM_AW      (SRAM_AW),
    .OCM_AW       (OCM_AW),
    .SELW         (SELW),
    .NUM_BG       (NUM_BG),
    .WORDS_PER_BG (WORDS_PER_BG),
    .BG_STRIDE    (BG_STRIDE)
  ) u_addr_gen (
    .Clk         (Clk),
    .Reset       (Reset),
    .i_sel       (bus.BG_Sel),
    .i_load_base (w_load_base),
    .i_incr      (w_incr),
    .o_addr      (bus.ADDR),
    .o_addr_ocm  (bus.addr_OCM),
    .o_words     (bus.words_written),
    .o_last      (w_last)
  );

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next state and counter/latch strobes; dropping load in any busy state aborts.
  always_comb begin
    w_state_next = r_state;
    w_load_base  = 1'b0;
    w_incr       = 1'b0;
    w_latch      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.load) w_state_next = S_SETUP;
      end
      S_SETUP: begin
        if (!bus.load) begin
          w_state_next = S_IDLE;
        end else begin
          w_load_base  = 1'b1;
          w_state_next = S_READ;
        end
      end
      S_READ: begin
        if (!bus.load) begin
          w_state_next = S_IDLE;
        end else if (bus.SRAM_done) begin
          if (w_sentinel_hit) begin
            w_state_next = S_DONE;
          end else begin
            w_latch      = 1'b1;
            w_state_next = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        // An accepted write always counts, even on the abort cycle.
        if (bus.ocm_ready) w_incr = 1'b1;
        if (!bus.load)          w_state_next = S_IDLE;
        else if (bus.ocm_ready) w_state_next = w_last ? S_DONE : S_READ;
      end
      S_DONE: begin
        if (!bus.load) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Write data is captured once per word and held until the OCM accepts it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)        r_data_out <= '0;
    else if (w_latch) r_data_out <= bus.DATA_IN;
  end

  assign bus.DATA_OUT = r_data_out;
  assign bus.reading  = (r_state == S_READ);
  assign bus.writing  = (r_state == S_WRITE);
  assign bus.busy     = (r_state == S_SETUP) || (r_state == S_READ) || (r_state == S_WRITE);
  assign bus.done     = (r_state == S_DONE);

endmodule : bg_copy_engine
`default_nettype wire

// File: tb/tb_bg_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bg_copy_engine
//  Purpose  : Directed self-checking bench for bg_copy_engine.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bg_copy_engine;

  logic Clk;
  logic Reset;
  int   total;
  int   bad;

  logic [15:0] mema [0:63];
  logic [15:0] memb [0:63];

  bg_copy_engine_if #(.DW(16), .SRAM_AW(20), .OCM_AW(19), .SELW(2)) ifa ();
  bg_copy_engine_if #(.DW(16), .SRAM_AW(20), .OCM_AW(19), .SELW(2)) ifb ();

  assign ifa.DATA_IN = mema[ifa.ADDR[5:0]];
  assign ifb.DATA_IN = memb[ifb.ADDR[5:0]];

  // Count-terminated copier: 8 words, stride 10, four backgrounds.
  bg_copy_engine #(
    .DW(16), .SRAM_AW(20), .OCM_AW(19), .NUM_BG(4), .SELW(2),
    .WORDS_PER_BG(8), .BG_STRIDE(10), .SENTINEL_EN(0), .SENTINEL(16'hF000)
  ) dut_a (.Clk(Clk), .Reset(Reset), .bus(ifa));

  // Sentinel-enabled copier with only two backgrounds.
  bg_copy_engine #(
    .DW(16), .SRAM_AW(20), .OCM_AW(19), .NUM_BG(2), .SELW(2),
    .WORDS_PER_BG(8), .BG_STRIDE(10), .SENTINEL_EN(1), .SENTINEL(16'hF000)
  ) dut_b (.Clk(Clk), .Reset(Reset), .bus(ifb));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    ifa.load = 0; ifa.BG_Sel = 0; ifa.SRAM_done = 1; ifa.ocm_ready = 1;
    ifb.load = 0; ifb.BG_Sel = 0; ifb.SRAM_done = 1; ifb.ocm_ready = 1;
    tick();
    total++;
    if ({ifa.reading, ifa.writing, ifa.busy, ifa.done, ifa.ADDR, ifa.addr_OCM,
         ifa.DATA_OUT, ifa.words_written} !== 78'd0) begin
      bad++; $display("FAIL reset_a got r%b w%b b%b d%b addr=%h ocm=%h dout=%h cnt=%h exp all zero",
        ifa.reading, ifa.writing, ifa.busy, ifa.done, ifa.ADDR, ifa.addr_OCM, ifa.DATA_OUT, ifa.words_written);
    end
    total++;
    if ({ifb.reading, ifb.writing, ifb.busy, ifb.done, ifb.ADDR, ifb.addr_OCM,
         ifb.DATA_OUT, ifb.words_written} !== 78'd0) begin
      bad++; $display("FAIL reset_b got r%b w%b b%b d%b addr=%h exp all zero",
        ifb.reading, ifb.writing, ifb.busy, ifb.done, ifb.ADDR);
    end
    @(negedge Clk);
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_normal_copy;
    ifa.BG_Sel = 0; ifa.SRAM_done = 1; ifa.ocm_ready = 1; ifa.load = 1;
    tick();
    total++;
    if ({ifa.reading, ifa.writing, ifa.busy, ifa.done} !== 4'b0010) begin
      bad++; $display("FAIL normal_setup got rwbd=%b exp 0010", {ifa.reading, ifa.writing, ifa.busy, ifa.done});
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      total++;
      if ({ifa.reading, ifa.writing, ifa.ADDR} !== {2'b10, 20'(k)}) begin
        bad++; $display("FAIL normal_read k=%0d got rw=%b addr=%h exp 10 addr=%h",
          k, {ifa.reading, ifa.writing}, ifa.ADDR, 20'(k));
      end
      tick();
      total++;
      if ({ifa.reading, ifa.writing, ifa.addr_OCM, ifa.DATA_OUT} !== {2'b01, 19'(k), 16'(16'h1000 + k)}) begin
        bad++; $display("FAIL normal_write k=%0d got rw=%b ocm=%h dout=%h exp 01 ocm=%h dout=%h",
          k, {ifa.reading, ifa.writing}, ifa.addr_OCM, ifa.DATA_OUT, 19'(k), 16'(16'h1000 + k));
      end
    end
    tick();
    total++;
    if ({ifa.busy, ifa.done, ifa.words_written, ifa.addr_OCM, ifa.ADDR} !== {2'b01, 19'd8, 19'd8, 20'd8}) begin
      bad++; $display("FAIL normal_done got bd=%b cnt=%h ocm=%h addr=%h exp 01 8 8 8",
        {ifa.busy, ifa.done}, ifa.words_written, ifa.addr_OCM, ifa.ADDR);
    end
    ifa.load = 0;
    tick();
    total++;
    if ({ifa.reading, ifa.writing, ifa.busy, ifa.done, ifa.words_written} !== {4'b0000, 19'd8}) begin
      bad++; $display("FAIL normal_idle got rwbd=%b cnt=%h exp 0000 cnt=8",
        {ifa.reading, ifa.writing, ifa.busy, ifa.done}, ifa.words_written);
    end
  endtask

  task automatic test_offset_stall;
    ifa.BG_Sel = 3; ifa.SRAM_done = 1; ifa.ocm_ready = 1; ifa.load = 1;
    tick();
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 0) ifa.BG_Sel = 1;
      total++;
      if ({ifa.reading, ifa.ADDR} !== {1'b1, 20'(30 + k)}) begin
        bad++; $display("FAIL offset_read k=%0d got r=%b addr=%h exp 1 addr=%h",
          k, ifa.reading, ifa.ADDR, 20'(30 + k));
      end
      if (k == 2) ifa.ocm_ready = 0;
      tick();
      total++;
      if ({ifa.writing, ifa.addr_OCM, ifa.DATA_OUT} !== {1'b1, 19'(k), 16'(16'h101E + k)}) begin
        bad++; $display("FAIL offset_write k=%0d got w=%b ocm=%h dout=%h exp 1 ocm=%h dout=%h",
          k, ifa.writing, ifa.addr_OCM, ifa.DATA_OUT, 19'(k), 16'(16'h101E + k));
      end
      if (k == 2) begin
        for (int s = 0; s < 3; s++) begin
          tick();
          total++;
          if ({ifa.writing, ifa.addr_OCM, ifa.DATA_OUT, ifa.words_written} !== {1'b1, 19'd2, 16'h1020, 19'd2}) begin
            bad++; $display("FAIL offset_stall s=%0d got w=%b ocm=%h dout=%h cnt=%h exp 1 2 1020 2",
              s, ifa.writing, ifa.addr_OCM, ifa.DATA_OUT, ifa.words_written);
          end
        end
        ifa.ocm_ready = 1;
      end
    end
    tick();
    total++;
    if ({ifa.done, ifa.words_written, ifa.ADDR} !== {1'b1, 19'd8, 20'd38}) begin
      bad++; $display("FAIL offset_done got d=%b cnt=%h addr=%h exp 1 8 26",
        ifa.done, ifa.words_written, ifa.ADDR);
    end
    ifa.load = 0;
    tick();
  endtask

  task automatic test_abort;
    ifa.BG_Sel = 1; ifa.SRAM_done = 1; ifa.ocm_ready = 1; ifa.load = 1;
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      tick();
      if (k == 3) begin
        total++;
        if ({ifa.writing, ifa.addr_OCM, ifa.words_written} !== {1'b1, 19'd3, 19'd3}) begin
          bad++; $display("FAIL abort_pre got w=%b ocm=%h cnt=%h exp 1 3 3",
            ifa.writing, ifa.addr_OCM, ifa.words_written);
        end
        ifa.load = 0;
      end
    end
    tick();
    total++;
    if ({ifa.reading, ifa.writing, ifa.busy, ifa.done, ifa.words_written, ifa.addr_OCM} !== {4'b0000, 19'd4, 19'd4}) begin
      bad++; $display("FAIL abort_idle got rwbd=%b cnt=%h ocm=%h exp 0000 4 4",
        {ifa.reading, ifa.writing, ifa.busy, ifa.done}, ifa.words_written, ifa.addr_OCM);
    end
    tick();
    total++;
    if ({ifa.busy, ifa.done} !== 2'b00) begin
      bad++; $display("FAIL abort_nodone got bd=%b exp 00", {ifa.busy, ifa.done});
    end
    ifa.load = 1;
    tick();
    tick();
    total++;
    if ({ifa.reading, ifa.ADDR, ifa.addr_OCM, ifa.words_written} !== {1'b1, 20'd10, 19'd0, 19'd0}) begin
      bad++; $display("FAIL abort_restart got r=%b addr=%h ocm=%h cnt=%h exp 1 a 0 0",
        ifa.reading, ifa.ADDR, ifa.addr_OCM, ifa.words_written);
    end
    ifa.load = 0;
    tick();
  endtask

  task automatic test_reset_mid_copy;
    ifa.BG_Sel = 1; ifa.SRAM_done = 1; ifa.ocm_ready = 1; ifa.load = 1;
    tick(); tick(); tick(); tick();
    ifa.SRAM_done = 0;
    tick();
    total++;
    if ({ifa.reading, ifa.ADDR, ifa.addr_OCM, ifa.words_written, ifa.DATA_OUT} !==
        {1'b1, 20'd11, 19'd1, 19'd1, 16'h100A}) begin
      bad++; $display("FAIL midrst_pre got r=%b addr=%h ocm=%h cnt=%h dout=%h exp 1 b 1 1 100a",
        ifa.reading, ifa.ADDR, ifa.addr_OCM, ifa.words_written, ifa.DATA_OUT);
    end
    #2 Reset = 1'b1;
    #1;
    total++;
    if ({ifa.reading, ifa.writing, ifa.busy, ifa.done, ifa.ADDR, ifa.addr_OCM,
         ifa.DATA_OUT, ifa.words_written} !== 78'd0) begin
      bad++; $display("FAIL midrst_async got rwbd=%b addr=%h ocm=%h dout=%h cnt=%h exp all zero",
        {ifa.reading, ifa.writing, ifa.busy, ifa.done}, ifa.ADDR, ifa.addr_OCM, ifa.DATA_OUT, ifa.words_written);
    end
    @(negedge Clk);
    Reset = 1'b0;
    tick();
    total++;
    if ({ifa.reading, ifa.writing, ifa.busy, ifa.done} !== 4'b0010) begin
      bad++; $display("FAIL midrst_setup got rwbd=%b exp 0010", {ifa.reading, ifa.writing, ifa.busy, ifa.done});
    end
    tick();
    total++;
    if ({ifa.reading, ifa.ADDR, ifa.addr_OCM} !== {1'b1, 20'd10, 19'd0}) begin
      bad++; $display("FAIL midrst_restart got r=%b addr=%h ocm=%h exp 1 a 0",
        ifa.reading, ifa.ADDR, ifa.addr_OCM);
    end
    ifa.load = 0; ifa.SRAM_done = 1;
    tick();
  endtask

  task automatic test_sentinel;
    memb[2] = 16'hF000;
    memb[4] = 16'hF001;
    ifb.BG_Sel = 0; ifb.SRAM_done = 1; ifb.ocm_ready = 1; ifb.load = 1;
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      tick();
      total++;
      if ({ifb.writing, ifb.addr_OCM, ifb.DATA_OUT} !==
          {1'b1, 19'(k), (k == 2) ? 16'hF000 : 16'(16'h2000 + k)}) begin
        bad++; $display("FAIL sentinel_write k=%0d got w=%b ocm=%h dout=%h",
          k, ifb.writing, ifb.addr_OCM, ifb.DATA_OUT);
      end
    end
    tick();
    total++;
    if ({ifb.reading, ifb.ADDR} !== {1'b1, 20'd4}) begin
      bad++; $display("FAIL sentinel_read got r=%b addr=%h exp 1 4", ifb.reading, ifb.ADDR);
    end
    tick();
    total++;
    if ({ifb.reading, ifb.writing, ifb.busy, ifb.done, ifb.words_written, ifb.addr_OCM, ifb.DATA_OUT} !==
        {4'b0001, 19'd4, 19'd4, 16'h2003}) begin
      bad++; $display("FAIL sentinel_done got rwbd=%b cnt=%h ocm=%h dout=%h exp 0001 4 4 2003",
        {ifb.reading, ifb.writing, ifb.busy, ifb.done}, ifb.words_written, ifb.addr_OCM, ifb.DATA_OUT);
    end
    ifb.load = 0;
    tick();
    memb[2] = 16'h2002;
    memb[4] = 16'h2004;
  endtask

  task automatic test_done_hold_bgsel;
    int n;
    ifb.BG_Sel = 2; ifb.SRAM_done = 1; ifb.ocm_ready = 1; ifb.load = 1;
    tick();
    tick();
    total++;
    if ({ifb.reading, ifb.ADDR} !== {1'b1, 20'd0}) begin
      bad++; $display("FAIL bgsel_base got r=%b addr=%h exp 1 0", ifb.reading, ifb.ADDR);
    end
    n = 0;
    while (!ifb.done && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (n >= 40) begin
      bad++; $display("FAIL bgsel_timeout got done=%b after %0d cycles exp 1", ifb.done, n);
    end
    total++;
    if ({ifb.words_written, ifb.DATA_OUT} !== {19'd8, 16'h2007}) begin
      bad++; $display("FAIL bgsel_final got cnt=%h dout=%h exp 8 2007", ifb.words_written, ifb.DATA_OUT);
    end
    for (int h = 0; h < 3; h++) begin
      tick();
      total++;
      if ({ifb.busy, ifb.done, ifb.words_written} !== {2'b01, 19'd8}) begin
        bad++; $display("FAIL done_hold h=%0d got bd=%b cnt=%h exp 01 8", h, {ifb.busy, ifb.done}, ifb.words_written);
      end
    end
    ifb.load = 0;
    #1;
    total++;
    if (ifb.done !== 1'b1) begin
      bad++; $display("FAIL done_same_cycle got %b exp 1", ifb.done);
    end
    tick();
    total++;
    if (ifb.done !== 1'b0) begin
      bad++; $display("FAIL done_fall got %b exp 0", ifb.done);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 64; i++) begin
      mema[i] = 16'(16'h1000 + i);
      memb[i] = 16'(16'h2000 + i);
    end
    test_reset();
    test_normal_copy();
    test_offset_stall();
    test_abort();
    test_reset_mid_copy();
    test_sentinel();
    test_done_hold_bgsel();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bg_copy_engine
`default_nettype wire
